sha256_block_compressor: RTL and testbench



---
 rtl/sha256_pkg.sv | 57 +++++
 rtl/sha256_block_compressor_if.sv | 24 ++
 rtl/sha256_msg_schedule.sv | 28 ++
 rtl/sha256_block_compressor.sv | 127 ++++++++++++
 tb/tb_sha256_block_compressor.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// SHA-256 constants, FSM state type and the round/schedule mixing functions,
// shared by the padding stage and the block compressor.
package sha256_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BLOCK_W = 512;
  localparam int unsigned HASH_W  = 256;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, OUT} state_e;

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam word_t IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_block_compressor_if.sv
// Padded-block input and digest output handshakes of the block compressor.
interface sha256_block_compressor_if;
  import sha256_pkg::*;

  logic                blk_valid;
  logic                blk_ready;
  logic [0:BLOCK_W-1]  blk_data;
  logic                blk_first;
  logic                blk_last;
  logic                digest_valid;
  logic                digest_ready;
  logic [0:HASH_W-1]   digest;
  logic                busy;

  modport master (
    output blk_valid, blk_data, blk_first, blk_last, digest_ready,
    input  blk_ready, digest_valid, digest, busy
  );

  modport slave (
    input  blk_valid, blk_data, blk_first, blk_last, digest_ready,
    output blk_ready, digest_valid, digest, busy
  );
endinterface

// File: rtl/sha256_msg_schedule.sv
// 16-word message schedule window: W_t is always the head word; each shift
// appends W_(t+16), computed from the words currently in the window.
module sha256_msg_schedule
  import sha256_pkg::*;
(
  input  logic               clk,
  input  logic               load,
  input  logic               shift,
  input  logic [0:BLOCK_W-1] block,
  output word_t              w_t
);

  word_t win_q [16];
  word_t next_w;

  assign next_w = small_sigma1(win_q[14]) + win_q[9] + small_sigma0(win_q[1]) + win_q[0];
  assign w_t    = win_q[0];

  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 16; i++) win_q[i] <= block[32*i +: 32];
    end else if (shift) begin
      for (int i = 0; i < 15; i++) win_q[i] <= win_q[i+1];
      win_q[15] <= next_w;
    end
  end

endmodule

// File: rtl/sha256_block_compressor.sv
// Iterative SHA-256 compression, one round per cycle, chaining H across the
// blocks of a message and holding the digest in a single output buffer.
module sha256_block_compressor
  import sha256_pkg::*;
#(
  parameter int unsigned ROUNDS = 64
) (
  input logic                      clk,
  input logic                      reset,
  sha256_block_compressor_if.slave bus
);

  if (ROUNDS != 64) begin : g_rounds_guard
    $error("sha256_block_compressor: ROUNDS must be 64");
  end

  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

  state_e            state_q;
  logic [5:0]        round_q;
  logic              last_q;
  word_t             hv_q   [8];
  word_t             work_q [8];
  logic              blk_ready_q;
  logic              digest_valid_q;
  logic              busy_q;
  logic [0:HASH_W-1] digest_q;

  logic  accept;
  word_t chain [8];
  word_t hsum  [8];
  word_t t1, t2;
  word_t w_t;

  assign accept           = bus.blk_valid && blk_ready_q;
  assign bus.blk_ready    = blk_ready_q;
  assign bus.digest_valid = digest_valid_q;
  assign bus.digest       = digest_q;
  assign bus.busy         = busy_q;

  sha256_msg_schedule u_sched (
    .clk   (clk),
    .load  (accept),
    .shift (state_q == ROUND),
    .block (bus.blk_data),
    .w_t   (w_t)
  );

  // work_q[0..7] are the working variables a..h
  always_comb begin
    t1 = work_q[7] + big_sigma1(work_q[4]) + ch(work_q[4], work_q[5], work_q[6])
       + K[round_q] + w_t;
    t2 = big_sigma0(work_q[0]) + maj(work_q[0], work_q[1], work_q[2]);
    for (int i = 0; i < 8; i++) begin
      chain[i] = bus.blk_first ? IV[i] : hv_q[i];
      hsum[i]  = hv_q[i] + work_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      round_q        <= '0;
      last_q         <= 1'b0;
      blk_ready_q    <= 1'b1;
      digest_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      digest_q       <= '0;
      for (int i = 0; i < 8; i++) begin
        hv_q[i]   <= IV[i];
        work_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            for (int i = 0; i < 8; i++) begin
              hv_q[i]   <= chain[i];
              work_q[i] <= chain[i];
            end
            round_q     <= '0;
            last_q      <= bus.blk_last;
            blk_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ROUND;
          end
        end
        ROUND: begin
          work_q[0] <= t1 + t2;
          work_q[1] <= work_q[0];
          work_q[2] <= work_q[1];
          work_q[3] <= work_q[2];
          work_q[4] <= work_q[3] + t1;
          work_q[5] <= work_q[4];
          work_q[6] <= work_q[5];
          work_q[7] <= work_q[6];
          round_q   <= round_q + 6'd1;
          if (round_q == LAST_ROUND) state_q <= FINAL;
        end
        FINAL: begin
          for (int i = 0; i < 8; i++) hv_q[i] <= hsum[i];
          if (last_q) begin
            digest_q       <= {hsum[0], hsum[1], hsum[2], hsum[3],
                               hsum[4], hsum[5], hsum[6], hsum[7]};
            digest_valid_q <= 1'b1;
            state_q        <= OUT;
          end else begin
            blk_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        OUT: begin
          // H stays as-is; the next message must start with blk_first
          if (bus.digest_ready) begin
            digest_valid_q <= 1'b0;
            blk_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_block_compressor.sv
// Directed-vector bench for sha256_block_compressor using FIPS 180-4 example digests.
module tb_sha256_block_compressor;

  logic clk = 1'b0;
  logic reset;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sha256_block_compressor_if bus();

  sha256_block_compressor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO_B1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_B2 = {480'h0, 32'h000001c0};

  localparam logic [255:0] ABC_DIG =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY_DIG =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] TWO_DIG =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  // Offer a block once blk_ready is seen; returns the index of the accepting edge.
  task automatic send_block(input logic [511:0] data, input logic first, input logic last,
                            output int acc_cyc);
    int n = 0;
    @(negedge clk);
    while (bus.blk_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.blk_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready_timeout: blk_ready=%b required 1", bus.blk_ready);
    end
    bus.blk_valid = 1'b1;
    bus.blk_data  = data;
    bus.blk_first = first;
    bus.blk_last  = last;
    acc_cyc = cyc + 1;
    @(negedge clk);
    bus.blk_valid = 1'b0;
  endtask

  task automatic wait_digest(output int seen_cyc);
    int n = 0;
    while (bus.digest_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.digest_valid !== 1'b1) begin
      errors++;
      $display("FAIL digest_timeout: digest_valid=%b required 1", bus.digest_valid);
      seen_cyc = -1;
    end else begin
      seen_cyc = cyc;
    end
  endtask

  task automatic take_digest();
    bus.digest_ready = 1'b1;
    @(negedge clk);
    bus.digest_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++; if (bus.blk_ready !== 1'b1) begin errors++; $display("FAIL reset_blk_ready: got %b required 1", bus.blk_ready); end
    checks++; if (bus.digest_valid !== 1'b0) begin errors++; $display("FAIL reset_digest_valid: got %b required 0", bus.digest_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
    checks++; if (bus.digest !== 256'h0) begin errors++; $display("FAIL reset_digest: got %h required 0", bus.digest); end
  endtask

  task automatic test_abc();
    int acc, seen;
    send_block(ABC_BLK, 1'b1, 1'b1, acc);
    checks++; if (bus.busy !== 1'b1 || bus.blk_ready !== 1'b0) begin errors++; $display("FAIL abc_busy_after_accept: busy=%b blk_ready=%b required 1/0", bus.busy, bus.blk_ready); end
    wait_digest(seen);
    checks++; if (seen - acc !== 65) begin errors++; $display("FAIL abc_latency: digest_valid after %0d edges required 65", seen - acc); end
    checks++; if (bus.digest !== ABC_DIG) begin errors++; $display("FAIL abc_digest: got %h required %h", bus.digest, ABC_DIG); end
    take_digest();
    checks++; if (bus.digest_valid !== 1'b0 || bus.blk_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL abc_release: dv=%b ready=%b busy=%b required 0/1/0", bus.digest_valid, bus.blk_ready, bus.busy); end
  endtask

  // digest_ready already high on entry to OUT
  task automatic test_empty();
    int acc, seen;
    bus.digest_ready = 1'b1;
    send_block(EMPTY_BLK, 1'b1, 1'b1, acc);
    wait_digest(seen);
    checks++; if (bus.digest !== EMPTY_DIG) begin errors++; $display("FAIL empty_digest: got %h required %h", bus.digest, EMPTY_DIG); end
    @(negedge clk);
    checks++; if (bus.digest_valid !== 1'b0 || bus.blk_ready !== 1'b1) begin errors++; $display("FAIL empty_quick_handshake: dv=%b ready=%b required 0/1", bus.digest_valid, bus.blk_ready); end
    bus.digest_ready = 1'b0;
  endtask

  task automatic test_two_block();
    int acc, seen, n;
    logic saw_dv;
    send_block(TWO_B1, 1'b1, 1'b0, acc);
    saw_dv = 1'b0;
    n = 0;
    while (bus.blk_ready !== 1'b1 && n < 100) begin
      if (bus.digest_valid === 1'b1) saw_dv = 1'b1;
      @(negedge clk);
      n++;
    end
    checks++; if (saw_dv !== 1'b0 || bus.digest_valid !== 1'b0) begin errors++; $display("FAIL two_no_mid_digest: saw digest_valid=%b required 0", saw_dv); end
    checks++; if (cyc - acc !== 65) begin errors++; $display("FAIL two_ready_return: after %0d edges required 65", cyc - acc); end
    send_block(TWO_B2, 1'b0, 1'b1, acc);
    wait_digest(seen);
    checks++; if (bus.digest !== TWO_DIG) begin errors++; $display("FAIL two_digest: got %h required %h", bus.digest, TWO_DIG); end
    take_digest();
  endtask

  task automatic test_back_to_back();
    int acc, seen;
    send_block(ABC_BLK, 1'b1, 1'b1, acc);
    wait_digest(seen);
    bus.blk_valid = 1'b1;
    bus.blk_data  = EMPTY_BLK;
    bus.blk_first = 1'b1;
    bus.blk_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++; if (bus.digest !== ABC_DIG || bus.digest_valid !== 1'b1) begin errors++; $display("FAIL stall_digest_hold[%0d]: dv=%b digest=%h required 1/%h", i, bus.digest_valid, bus.digest, ABC_DIG); end
      checks++; if (bus.blk_ready !== 1'b0) begin errors++; $display("FAIL stall_blk_ready[%0d]: got %b required 0", i, bus.blk_ready); end
      @(negedge clk);
    end
    bus.blk_valid = 1'b0;
    take_digest();
    checks++; if (bus.blk_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL stall_release: ready=%b busy=%b required 1/0", bus.blk_ready, bus.busy); end
    send_block(ABC_BLK, 1'b1, 1'b1, acc);
    wait_digest(seen);
    checks++; if (seen - acc !== 65) begin errors++; $display("FAIL b2b_latency: after %0d edges required 65", seen - acc); end
    checks++; if (bus.digest !== ABC_DIG) begin errors++; $display("FAIL b2b_digest: got %h required %h", bus.digest, ABC_DIG); end
    take_digest();
  endtask

  // Resend after the abort omits blk_first: H must have reset to IV
  task automatic test_reset_mid_round();
    int acc, seen;
    logic saw_dv;
    send_block(ABC_BLK, 1'b1, 1'b1, acc);
    while (cyc < acc + 30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (bus.blk_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL abort_state: ready=%b busy=%b required 1/0", bus.blk_ready, bus.busy); end
    checks++; if (bus.digest_valid !== 1'b0 || bus.digest !== 256'h0) begin errors++; $display("FAIL abort_outputs: dv=%b digest=%h required 0/0", bus.digest_valid, bus.digest); end
    saw_dv = 1'b0;
    for (int i = 0; i < 70; i++) begin
      if (bus.digest_valid === 1'b1) saw_dv = 1'b1;
      @(negedge clk);
    end
    checks++; if (saw_dv !== 1'b0) begin errors++; $display("FAIL abort_no_digest: digest_valid seen=%b required 0", saw_dv); end
    send_block(ABC_BLK, 1'b0, 1'b1, acc);
    wait_digest(seen);
    checks++; if (seen - acc !== 65) begin errors++; $display("FAIL resend_latency: after %0d edges required 65", seen - acc); end
    checks++; if (bus.digest !== ABC_DIG) begin errors++; $display("FAIL resend_digest: got %h required %h", bus.digest, ABC_DIG); end
    take_digest();
  endtask

  task automatic test_delayed_second_block();
    int acc, seen, n;
    send_block(TWO_B1, 1'b1, 1'b0, acc);
    bus.blk_data  = EMPTY_BLK;
    bus.blk_first = 1'b1;
    bus.blk_last  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.blk_valid = (i % 3 == 0);
      @(negedge clk);
    end
    bus.blk_valid = 1'b0;
    n = 0;
    while (bus.blk_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++; if (cyc - acc !== 65) begin errors++; $display("FAIL delayed_ready_return: after %0d edges required 65", cyc - acc); end
    repeat (20) @(negedge clk);
    checks++; if (bus.blk_ready !== 1'b1 || bus.busy !== 1'b0 || bus.digest_valid !== 1'b0) begin errors++; $display("FAIL delayed_idle_wait: ready=%b busy=%b dv=%b required 1/0/0", bus.blk_ready, bus.busy, bus.digest_valid); end
    send_block(TWO_B2, 1'b0, 1'b1, acc);
    wait_digest(seen);
    checks++; if (seen - acc !== 65) begin errors++; $display("FAIL delayed_latency: after %0d edges required 65", seen - acc); end
    checks++; if (bus.digest !== TWO_DIG) begin errors++; $display("FAIL delayed_digest: got %h required %h", bus.digest, TWO_DIG); end
    take_digest();
  endtask

  initial begin
    reset            = 1'b1;
    bus.blk_valid    = 1'b0;
    bus.blk_data     = '0;
    bus.blk_first    = 1'b0;
    bus.blk_last     = 1'b0;
    bus.digest_ready = 1'b0;
    test_reset();
    test_abc();
    test_empty();
    test_two_block();
    test_back_to_back();
    test_reset_mid_round();
    test_delayed_second_block();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
